// File: rtl/alu64_if.sv
// Operand/result bundle between the execute-stage controller and the ALU.
// The master drives the operands and opcode, and the slave returns the registered result.
interface alu64_if #(
    parameter int WIDTH = 64
);
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [3:0]       control;
    logic [WIDTH-1:0] result;
    logic             zero;

    modport master (
        output a,
        output b,
        output control,
        input  result,
        input  zero
    );

    modport slave (
        input  a,
        input  b,
        input  control,
        output result,
        output zero
    );
endinterface

// File: rtl/alu64.sv
// Registered integer ALU for the execute stage: AND/OR/ADD/SUB/pass-B/NOR with a zero flag.
// One operation per cycle, one-cycle latency, synchronous active-high reset.
module alu64 #(
    parameter int WIDTH = 64
) (
    input  logic   clk,
    input  logic   reset,
    alu64_if.slave bus
);
    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_PASS = 4'b0111;
    localparam logic [3:0] OP_NOR  = 4'b1100;

    logic [WIDTH-1:0] next_result_s;
    logic             next_zero_s;
    logic [WIDTH-1:0] result_r;
    logic             zero_r;

    function automatic logic is_zero(input logic [WIDTH-1:0] value);
        return (value == {WIDTH{1'b0}});
    endfunction

    // Operation decode; unlisted codes yield zero so branch logic sees a defined value.
    always_comb begin
        next_result_s = {WIDTH{1'b0}};
        case (bus.control)
            OP_AND:  next_result_s = bus.a & bus.b;
            OP_OR:   next_result_s = bus.a | bus.b;
            OP_ADD:  next_result_s = bus.a + bus.b;
            OP_SUB:  next_result_s = bus.a - bus.b;
            OP_PASS: next_result_s = bus.b;
            OP_NOR:  next_result_s = ~(bus.a | bus.b);
            default: next_result_s = {WIDTH{1'b0}};
        endcase
        next_zero_s = is_zero(next_result_s);
    end

    // Output register; zero comes from the same value being captured so the pair never disagrees.
    always_ff @(posedge clk) begin
        if (reset) begin
            result_r <= {WIDTH{1'b0}};
            zero_r   <= 1'b1;
        end else begin
            result_r <= next_result_s;
            zero_r   <= next_zero_s;
        end
    end

    assign bus.result = result_r;
    assign bus.zero   = zero_r;
endmodule

// File: tb/tb_alu64.sv
// Directed self-checking bench for alu64: reset, each opcode, wrap-around and one-cycle latency.
module tb_alu64;
    localparam int WIDTH = 64;
    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};

    logic clk;
    logic reset;
    int   tests_run;
    int   tests_failed;

    alu64_if #(.WIDTH(WIDTH)) bus ();

    alu64 #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [WIDTH-1:0] exp_result, input logic exp_zero);
        tests_run++;
        assert (bus.result === exp_result) else begin
            tests_failed++;
            $error("FAIL %s result observed=%h expected=%h", tag, bus.result, exp_result);
        end
        tests_run++;
        assert (bus.zero === exp_zero) else begin
            tests_failed++;
            $error("FAIL %s zero observed=%b expected=%b", tag, bus.zero, exp_zero);
        end
    endtask

    task automatic drive(input logic [3:0] ctl, input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb);
        bus.control = ctl;
        bus.a       = va;
        bus.b       = vb;
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;

        reset = 1'b1;
        drive(4'b0010, 64'd5, 64'd7);
        step();
        check("reset", 64'd0, 1'b1);

        reset = 1'b0;
        step();
        check("reset_release_add", 64'd12, 1'b0);

        drive(4'b0010, 64'd1, 64'd2);
        step();
        check("add_1_2", 64'd3, 1'b0);

        drive(4'b0110, 64'd1, 64'd2);
        step();
        check("sub_1_2", ALL_ONES, 1'b0);

        drive(4'b0110, 64'h1234, 64'h1234);
        step();
        check("sub_equal", 64'd0, 1'b1);

        drive(4'b0110, 64'd100, 64'd58);
        step();
        check("sub_100_58", 64'd42, 1'b0);

        drive(4'b0001, 64'd2, 64'd1);
        step();
        check("or_2_1", 64'd3, 1'b0);

        drive(4'b0001, 64'hF0F0, 64'h0F00);
        step();
        check("or_pattern", 64'hFFF0, 1'b0);

        drive(4'b0000, 64'd2, 64'd1);
        step();
        check("and_2_1", 64'd0, 1'b1);

        drive(4'b0000, 64'hF0F0, 64'hFF00);
        step();
        check("and_pattern", 64'hF000, 1'b0);

        drive(4'b1100, 64'd0, 64'd0);
        step();
        check("nor_zero", ALL_ONES, 1'b0);

        drive(4'b1100, 64'h00FF_0000_0000_00F0, 64'hFF00_0000_0000_000F);
        step();
        check("nor_pattern", 64'h0000_FFFF_FFFF_FF00, 1'b0);

        drive(4'b0111, 64'd9, 64'd0);
        step();
        check("pass_b_zero", 64'd0, 1'b1);

        drive(4'b0111, 64'd0, 64'hDEAD_BEEF);
        step();
        check("pass_b_value", 64'hDEAD_BEEF, 1'b0);

        drive(4'b1000, 64'd2, 64'd1);
        step();
        check("undef_1000", 64'd0, 1'b1);

        drive(4'b0011, 64'd5, 64'd3);
        step();
        check("undef_0011", 64'd0, 1'b1);

        drive(4'b0010, ALL_ONES, 64'd1);
        step();
        check("add_wrap", 64'd0, 1'b1);

        // Inputs changed between edges must not disturb the registered outputs.
        drive(4'b0010, 64'd40, 64'd2);
        step();
        check("latency_first", 64'd42, 1'b0);
        #2;
        drive(4'b0001, 64'h100, 64'h001);
        #1;
        check("latency_hold", 64'd42, 1'b0);
        step();
        check("latency_update", 64'h101, 1'b0);

        // Reset mid-stream wins over valid inputs; the first edge after release captures them.
        drive(4'b0010, 64'd1, 64'd2);
        reset = 1'b1;
        step();
        check("reset_midstream", 64'd0, 1'b1);
        reset = 1'b0;
        step();
        check("reset_midstream_release", 64'd3, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/alu64.md
Name:
alu64

Overview:
- 64-bit integer ALU for the single-cycle datapath (execute stage).
- Performs AND, OR, ADD, SUB, pass-B and NOR on two operands, selected by a 4-bit control code.
- Produces the result and a zero flag for conditional branches.
- Outputs are registered: one result per clock, one-cycle latency, synchronous active-high reset.

Parameters:
- WIDTH, 64, operand and result width in bits; all behaviour below scales with WIDTH.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- control  input  4  operation select.
- zero  output  1  registered; 1 when the registered result equals 0.
- result  output  WIDTH  registered operation result.

Behaviour:
- Operation decode (combinational, from a, b and control):
  - 4'b0000: a AND b.
  - 4'b0001: a OR b.
  - 4'b0010: a + b, modulo 2^WIDTH; carry-out discarded.
  - 4'b0110: a − b, modulo 2^WIDTH (two's complement); borrow discarded.
  - 4'b0111: pass b.
  - 4'b1100: NOR(a, b).
  - Any other code (including 4'b1000): next result = 0.
- Arithmetic is unsigned/two's complement with identical bit patterns. No overflow, carry or sign outputs.
- Output register, rising edge of clk:
  - reset = 1: result <= 0, zero <= 1. Reset has priority over all inputs.
  - reset = 0: result <= next result; zero <= (next result == 0).
- zero is computed from the same next-result value that is captured, so zero and result always agree. Zero is never derived from the previously registered result.
- Latency is exactly one cycle; throughput is one operation per cycle. No handshake: inputs are sampled every edge.
- Changing control, a or b between edges has no effect on the outputs until the next edge.
- Reset asserted mid-stream: the edge with reset = 1 clears the outputs. The first edge with reset = 0 captures the current inputs.
- Undefined (X) control is not required to be handled. The implementation must not infer latches: use a default branch for the decode.
- No internal state other than the result and zero registers.

Test Plan:
- Reset: hold reset = 1 for one edge with a = 5, b = 7, control = 0010 -> result = 0, zero = 1. Release reset; next edge -> result = 12, zero = 0.
- ADD and SUB:
  - control = 0010, a = 1, b = 2 -> after one edge result = 3, zero = 0.
  - control = 0110, a = 1, b = 2 -> result = 0xFFFF_FFFF_FFFF_FFFF (18446744073709551615), zero = 0.
  - a = b = 0x1234 with control = 0110 -> result = 0, zero = 1.
- Logic ops:
  - control = 0001, a = 2, b = 1 -> result = 3, zero = 0.
  - control = 0000, a = 2, b = 1 -> result = 0, zero = 1.
  - control = 1100, a = 0, b = 0 -> result = all ones, zero = 0.
- Pass and unspecified codes:
  - control = 0111, a = 9, b = 0 -> result = 0, zero = 1.
  - control = 1000, a = 2, b = 1 -> result = 0, zero = 1.
- Wrap and latency: control = 0010, a = 0xFFFF_FFFF_FFFF_FFFF, b = 1 -> result = 0, zero = 1.
  - Change inputs between edges and confirm the outputs only update at the next rising edge.
